// File: rtl/motor_pkg.sv
// Shared motor-drive definitions: H-bridge direction codes, drive FSM states
// and the shoot-through guard applied to raw direction codes.
package motor_pkg;

  localparam logic [3:0] STOP  = 4'b0000;
  localparam logic [3:0] FWD   = 4'b1001;
  localparam logic [3:0] BACK  = 4'b0110;
  localparam logic [3:0] RIGHT = 4'b0101;
  localparam logic [3:0] LEFT  = 4'b1010;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DEAD  = 2'd1,
    DRIVE = 2'd2,
    FAULT = 2'd3
  } state_e;

  // A pair of 11 would short a bridge leg, so it collapses to 00 (coast).
  function automatic logic [3:0] guard_dir(input logic [3:0] d);
    logic [3:0] g;
    g[1:0] = (d[1:0] == 2'b11) ? 2'b00 : d[1:0];
    g[3:2] = (d[3:2] == 2'b11) ? 2'b00 : d[3:2];
    return g;
  endfunction

endpackage

// File: rtl/hbridge_drive_stage_if.sv
// Bundle between the direction controller / bridge comparators and the
// H-bridge drive stage.
interface hbridge_drive_stage_if #(
  parameter int PWM_BITS = 8
);
  logic [3:0]          dir_in;
  logic [PWM_BITS-1:0] duty;
  logic                compA;
  logic                compB;
  logic [3:0]          hb_in;
  logic                ena;
  logic                enb;
  logic                fault;
  logic                busy;

  modport master (
    output dir_in, duty, compA, compB,
    input  hb_in, ena, enb, fault, busy
  );

  modport slave (
    input  dir_in, duty, compA, compB,
    output hb_in, ena, enb, fault, busy
  );
endinterface

// File: rtl/pwm_gen.sv
// Free-running PWM counter with a single compare; one instance serves both
// bridge enables.
module pwm_gen #(
  parameter int PWM_BITS = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [PWM_BITS-1:0] cmp_duty,
  output logic                pwm_on
);

  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;

  always_comb begin
    pwm_cnt_d = pwm_cnt_q + 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) pwm_cnt_q <= '0;
    else       pwm_cnt_q <= pwm_cnt_d;
  end

  assign pwm_on = (pwm_cnt_q < cmp_duty);

endmodule

// File: rtl/hbridge_drive_stage.sv
// Dual H-bridge drive stage: dead-time between direction codes, soft-start
// duty ramp and a latched overcurrent shutdown with a clean-hold release.
module hbridge_drive_stage
  import motor_pkg::*;
#(
  parameter int PWM_BITS    = 8,
  parameter int DEAD_CYCLES = 1000,
  parameter int RAMP_DIV    = 256,
  parameter int FAULT_HOLD  = 10_000_000
) (
  input  logic                  clock,
  input  logic                  reset,
  hbridge_drive_stage_if.slave  bus
);

  localparam int DEAD_W = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
  localparam int RAMP_W = (RAMP_DIV    > 1) ? $clog2(RAMP_DIV)    : 1;
  localparam int HOLD_W = (FAULT_HOLD  > 1) ? $clog2(FAULT_HOLD)  : 1;

  localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_CYCLES - 1);
  localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(FAULT_HOLD - 1);

  logic [3:0]          dir_r_q, dir_r_d;
  logic [1:0]          sync_a_q, sync_a_d;
  logic [1:0]          sync_b_q, sync_b_d;
  state_e              state_q, state_d;
  logic [DEAD_W-1:0]   dead_cnt_q, dead_cnt_d;
  logic [3:0]          dead_code_q, dead_code_d;
  logic [3:0]          applied_q, applied_d;
  logic [PWM_BITS-1:0] cur_duty_q, cur_duty_d;
  logic [RAMP_W-1:0]   ramp_cnt_q, ramp_cnt_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;

  logic [3:0] dir_s;
  logic       flt;
  logic       pwm_on;

  assign dir_s = guard_dir(dir_r_q);
  assign flt   = !sync_a_q[1] | !sync_b_q[1];

  pwm_gen #(.PWM_BITS(PWM_BITS)) u_pwm (
    .clock    (clock),
    .reset    (reset),
    .cmp_duty (cur_duty_q),
    .pwm_on   (pwm_on)
  );

  always_comb begin
    dir_r_d     = bus.dir_in;
    sync_a_d    = {sync_a_q[0], bus.compA};
    sync_b_d    = {sync_b_q[0], bus.compB};
    state_d     = state_q;
    dead_cnt_d  = dead_cnt_q;
    dead_code_d = dead_code_q;
    applied_d   = applied_q;
    cur_duty_d  = cur_duty_q;
    ramp_cnt_d  = ramp_cnt_q;
    hold_cnt_d  = hold_cnt_q;

    if (flt) begin
      state_d    = FAULT;
      hold_cnt_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (dir_s != STOP) begin
            state_d     = DEAD;
            dead_cnt_d  = '0;
            dead_code_d = dir_s;
          end
        end
        DEAD: begin
          if (dir_s == STOP) begin
            state_d = IDLE;
          end else if (dir_s != dead_code_q) begin
            // A new target code must see a full dead interval of its own.
            dead_cnt_d  = '0;
            dead_code_d = dir_s;
          end else if (dead_cnt_q == DEAD_LAST) begin
            state_d    = DRIVE;
            applied_d  = dir_s;
            cur_duty_d = '0;
            ramp_cnt_d = '0;
          end else begin
            dead_cnt_d = dead_cnt_q + 1'b1;
          end
        end
        DRIVE: begin
          ramp_cnt_d = (ramp_cnt_q == RAMP_LAST) ? '0 : ramp_cnt_q + 1'b1;
          if (bus.duty < cur_duty_q)
            cur_duty_d = bus.duty;
          else if (ramp_cnt_q == RAMP_LAST && cur_duty_q < bus.duty)
            cur_duty_d = cur_duty_q + 1'b1;
          if (dir_s == STOP) begin
            state_d = IDLE;
          end else if (dir_s != applied_q) begin
            state_d     = DEAD;
            dead_cnt_d  = '0;
            dead_code_d = dir_s;
          end
        end
        FAULT: begin
          if (hold_cnt_q == HOLD_LAST) begin
            state_d    = IDLE;
            cur_duty_d = '0;
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs decode straight from registered state so async reset clears them at once.
  always_comb begin
    bus.hb_in = 4'b0000;
    bus.ena   = 1'b0;
    bus.enb   = 1'b0;
    bus.fault = 1'b0;
    bus.busy  = 1'b0;
    unique case (state_q)
      DEAD:  bus.busy = 1'b1;
      DRIVE: begin
        bus.hb_in = applied_q;
        bus.ena   = pwm_on && (applied_q[1:0] != 2'b00);
        bus.enb   = pwm_on && (applied_q[3:2] != 2'b00);
      end
      FAULT: bus.fault = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dir_r_q     <= 4'b0000;
      sync_a_q    <= 2'b11;
      sync_b_q    <= 2'b11;
      state_q     <= IDLE;
      dead_cnt_q  <= '0;
      dead_code_q <= 4'b0000;
      applied_q   <= 4'b0000;
      cur_duty_q  <= '0;
      ramp_cnt_q  <= '0;
      hold_cnt_q  <= '0;
    end else begin
      dir_r_q     <= dir_r_d;
      sync_a_q    <= sync_a_d;
      sync_b_q    <= sync_b_d;
      state_q     <= state_d;
      dead_cnt_q  <= dead_cnt_d;
      dead_code_q <= dead_code_d;
      applied_q   <= applied_d;
      cur_duty_q  <= cur_duty_d;
      ramp_cnt_q  <= ramp_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

endmodule

// File: tb/tb_hbridge_drive_stage.sv
// Directed bench for the H-bridge drive stage with short dead/ramp/hold
// parameters; expected values are hand-derived clock counts.
module tb_hbridge_drive_stage;
  import motor_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  hbridge_drive_stage_if #(.PWM_BITS(8)) bus ();

  hbridge_drive_stage #(
    .PWM_BITS    (8),
    .DEAD_CYCLES (8),
    .RAMP_DIV    (4),
    .FAULT_HOLD  (16)
  ) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic count_en(input int n, output int ca, output int cb);
    ca = 0;
    cb = 0;
    for (int i = 0; i < n; i++) begin
      step(1);
      ca = ca + (bus.ena ? 1 : 0);
      cb = cb + (bus.enb ? 1 : 0);
    end
  endtask

  int ca, cb;

  initial begin
    bus.dir_in = STOP;
    bus.duty   = 8'd0;
    bus.compA  = 1'b1;
    bus.compB  = 1'b1;
    #2;
    check_eq("reset_hb",    32'(bus.hb_in), 32'(4'b0000));
    check_eq("reset_flags", 32'({bus.ena, bus.enb, bus.fault, bus.busy}), 32'(4'b0000));
    check_eq("reset_state", 32'(dut.state_q), 32'(IDLE));
    #10 rst = 1'b0;
    step(2);

    // Test 1: FWD with soft start to 64
    bus.duty   = 8'd64;
    bus.dir_in = FWD;
    step(2);
    check_eq("t1_dead_start", 32'({bus.hb_in, bus.busy}), 32'({4'b0000, 1'b1}));
    step(7);
    check_eq("t1_dead_end",   32'({bus.hb_in, bus.busy}), 32'({4'b0000, 1'b1}));
    step(1);
    check_eq("t1_drive_hb",   32'({bus.hb_in, bus.busy}), 32'({FWD, 1'b0}));
    check_eq("t1_duty0",      32'(dut.cur_duty_q), 32'd0);
    step(4);
    check_eq("t1_duty1",      32'(dut.cur_duty_q), 32'd1);
    step(4);
    check_eq("t1_duty2",      32'(dut.cur_duty_q), 32'd2);
    step(4 * 62);
    check_eq("t1_duty64",     32'(dut.cur_duty_q), 32'd64);
    step(8);
    check_eq("t1_duty_hold",  32'(dut.cur_duty_q), 32'd64);
    count_en(256, ca, cb);
    check_eq("t1_ena_count",  32'(ca), 32'd64);
    check_eq("t1_enb_count",  32'(cb), 32'd64);
    bus.duty = 8'd32;
    step(1);
    check_eq("t1_duty_drop",  32'(dut.cur_duty_q), 32'd32);

    // Test 2: FWD -> BACK
    bus.dir_in = BACK;
    step(1);
    check_eq("t2_latency1",   32'(bus.hb_in), 32'(FWD));
    step(1);
    check_eq("t2_latency2",   32'({bus.hb_in, bus.busy}), 32'({4'b0000, 1'b1}));
    step(7);
    check_eq("t2_dead_end",   32'(bus.hb_in), 32'(4'b0000));
    step(1);
    check_eq("t2_back",       32'(bus.hb_in), 32'(BACK));
    check_eq("t2_ramp_rst",   32'(dut.cur_duty_q), 32'd0);
    step(4);
    check_eq("t2_ramp1",      32'(dut.cur_duty_q), 32'd1);

    // Test 3: 1111 acts as STOP; half-illegal code keeps only the legal pair
    bus.dir_in = 4'b1111;
    step(2);
    check_eq("t3_state",      32'(dut.state_q), 32'(IDLE));
    step(12);
    check_eq("t3_stay_idle",  32'({bus.hb_in, bus.busy}), 32'({4'b0000, 1'b0}));
    bus.dir_in = 4'b1101;
    step(10);
    check_eq("t3_guard_hb",   32'(bus.hb_in), 32'(4'b0001));
    count_en(256, ca, cb);
    check_eq("t3_enb_off",    32'(cb), 32'd0);

    // Test 4: single-clock compA glitch during DRIVE
    bus.dir_in = FWD;
    step(10);
    check_eq("t4_drive",      32'(bus.hb_in), 32'(FWD));
    bus.compA = 1'b0;
    step(1);
    bus.compA = 1'b1;
    step(1);
    check_eq("t4_pre_fault",  32'({bus.hb_in, bus.fault}), 32'({FWD, 1'b0}));
    step(1);
    check_eq("t4_fault",      32'({bus.hb_in, bus.ena, bus.enb, bus.fault}), 32'({4'b0000, 3'b001}));
    step(15);
    check_eq("t4_hold_end",   32'(bus.fault), 32'd1);
    step(1);
    check_eq("t4_release",    32'({bus.fault, 2'(dut.state_q)}), 32'({1'b0, IDLE}));
    check_eq("t4_duty_clr",   32'(dut.cur_duty_q), 32'd0);
    step(1);
    check_eq("t4_redead",     32'(bus.busy), 32'd1);
    step(8);
    check_eq("t4_redrive",    32'(bus.hb_in), 32'(FWD));

    // Test 5: compB held low
    bus.compB = 1'b0;
    step(3);
    check_eq("t5_fault",      32'(bus.fault), 32'd1);
    step(100);
    check_eq("t5_fault_held", 32'({bus.hb_in, bus.fault}), 32'({4'b0000, 1'b1}));
    bus.compB = 1'b1;
    step(20);
    check_eq("t5_recover",    32'(bus.fault), 32'd0);

    // Test 6: asynchronous reset mid-DEAD and mid-DRIVE
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(6);
    check_eq("t6_in_dead",    32'(bus.busy), 32'd1);
    #3 rst = 1'b1;
    #1;
    check_eq("t6_dead_rst",   32'({bus.hb_in, bus.busy, 2'(dut.state_q)}), 32'({4'b0000, 1'b0, IDLE}));
    #1 rst = 1'b0;
    step(30);
    check_eq("t6_in_drive",   32'({bus.hb_in, dut.cur_duty_q}), 32'({FWD, 8'd5}));
    #3 rst = 1'b1;
    #1;
    check_eq("t6_drive_rst",  32'({bus.hb_in, bus.ena, bus.enb, 2'(dut.state_q)}), 32'({4'b0000, 2'b00, IDLE}));
    check_eq("t6_duty_rst",   32'(dut.cur_duty_q), 32'd0);
    #1 rst = 1'b0;
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
